// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: bus widths, bus layouts,
// ld_op and ex_cause bit indices.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_W = 144;
  localparam int MS_TO_WS_BUS_W = 137;
  localparam int DROP_CNT_BITS  = 2;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  localparam int EX_CAUSE_W = 17;
  localparam int EXC_ALE    = 3;

  typedef struct packed {
    logic                  mem_we;
    logic                  rdcntid;
    logic                  ertn;
    logic                  csr_we;
    logic                  csr_rd;
    logic [31:0]           csr_wmask;
    logic [13:0]           csr_num;
    logic [EX_CAUSE_W-1:0] ex_cause;
    logic [4:0]            ld_op;
    logic                  res_from_mem;
    logic                  gr_we;
    logic [4:0]            dest;
    logic [31:0]           result;
    logic [31:0]           pc;
  } es_to_ms_t;

  // Everything the stage keeps once the memory request has been issued.
  typedef struct packed {
    logic                  rdcntid;
    logic                  ertn;
    logic                  csr_we;
    logic                  csr_rd;
    logic [31:0]           csr_wmask;
    logic [13:0]           csr_num;
    logic [EX_CAUSE_W-1:0] ex_cause;
    logic [4:0]            ld_op;
    logic                  res_from_mem;
    logic                  gr_we;
    logic [4:0]            dest;
    logic [31:0]           result;
    logic [31:0]           pc;
  } ms_inst_t;

  typedef struct packed {
    logic                  rdcntid;
    logic                  ertn;
    logic                  csr_we;
    logic                  csr_rd;
    logic [31:0]           csr_wmask;
    logic [13:0]           csr_num;
    logic [EX_CAUSE_W-1:0] ex_cause;
    logic                  gr_we;
    logic [4:0]            dest;
    logic [31:0]           final_result;
    logic [31:0]           pc;
  } ms_to_ws_t;

  function automatic ms_inst_t to_inst(input es_to_ms_t e);
    ms_inst_t m;
    m.rdcntid      = e.rdcntid;
    m.ertn         = e.ertn;
    m.csr_we       = e.csr_we;
    m.csr_rd       = e.csr_rd;
    m.csr_wmask    = e.csr_wmask;
    m.csr_num      = e.csr_num;
    m.ex_cause     = e.ex_cause;
    m.ld_op        = e.ld_op;
    m.res_from_mem = e.res_from_mem;
    m.gr_we        = e.gr_we;
    m.dest         = e.dest;
    m.result       = e.result;
    m.pc           = e.pc;
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the byte/half addressed by addr and
// sign- or zero-extends it according to the one-hot ld_op.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [4:0]  ld_op,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = lane[addr];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    value = '0;
    if (ld_op[LD_W])  value = rdata;
    if (ld_op[LD_HU]) value = {16'b0, half_sel};
    if (ld_op[LD_H])  value = {{16{half_sel[15]}}, half_sel};
    if (ld_op[LD_BU]) value = {24'b0, byte_sel};
    if (ld_op[LD_B])  value = {{24{byte_sel[7]}}, byte_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// LoongArch memory stage: waits for data SRAM responses, extracts load data,
// forwards to decode and discards responses orphaned by a flush.
// Optional MS_LOAD_BYPASS_EN: forward load data combinationally in the data_ok cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ES_TO_MS_W = ES_TO_MS_BUS_W,
  parameter int MS_TO_WS_W = MS_TO_WS_BUS_W,
  parameter int DROP_CNT_W = DROP_CNT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ws_allowin,
  output logic                  ms_allowin,
  input  logic                  es_to_ms_valid,
  input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  output logic [4:0]            ms_to_ds_dest,
  output logic [31:0]           ms_to_ds_value,
  output logic                  ms_value_from_mem,
  input  logic                  ws_reflush_ms,
  output logic                  ms_int,
  output logic                  ms_csr,
  output logic                  ms_tid
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  es_to_ms_t             es_in;
  ms_inst_t              inst_q, inst_d;
  logic                  ms_valid_q, ms_valid_d;
  logic                  wait_resp_q, wait_resp_d;
  logic                  data_buf_v_q, data_buf_v_d;
  logic [31:0]           data_buf_q, data_buf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  resp_take;
  logic                  ms_ready_go;
  logic                  accept;
  logic                  new_wait;
  logic                  drop_inc;
  logic                  drop_dec;
  logic [31:0]           load_src;
  logic [31:0]           load_val;
  logic [31:0]           final_result;
  ms_to_ws_t             ws_out;

  always_comb begin
    es_in       = es_to_ms_t'(es_to_ms_bus);
    resp_take   = wait_resp_q & data_sram_data_ok & (drop_cnt_q == '0);
    ms_ready_go = !wait_resp_q | (data_sram_data_ok & (drop_cnt_q == '0));
    ms_allowin  = !ms_valid_q | (ms_ready_go & ws_allowin);
    accept      = es_to_ms_valid & ms_allowin & !ws_reflush_ms;
    // Execute only issues a request for an exception-free load or store.
    new_wait    = (es_in.res_from_mem | es_in.mem_we) & (es_in.ex_cause == '0);
    drop_inc    = ws_reflush_ms & wait_resp_q & !resp_take;
    drop_dec    = data_sram_data_ok & (drop_cnt_q != '0);
  end

  always_comb begin
    ms_valid_d   = ms_valid_q;
    wait_resp_d  = wait_resp_q;
    data_buf_v_d = data_buf_v_q;
    data_buf_d   = data_buf_q;
    inst_d       = accept ? to_inst(es_in) : inst_q;
    if (ws_reflush_ms) begin
      ms_valid_d   = 1'b0;
      wait_resp_d  = 1'b0;
      data_buf_v_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d   = es_to_ms_valid;
      wait_resp_d  = es_to_ms_valid & new_wait;
      data_buf_v_d = 1'b0;
    end else if (resp_take) begin
      // Taking a response without leaving means writeback is stalled: hold the data.
      wait_resp_d  = 1'b0;
      data_buf_v_d = 1'b1;
      data_buf_d   = data_sram_rdata;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (drop_dec && !drop_inc) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      wait_resp_q  <= 1'b0;
      data_buf_v_q <= 1'b0;
      data_buf_q   <= '0;
      drop_cnt_q   <= '0;
      inst_q       <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      wait_resp_q  <= wait_resp_d;
      data_buf_v_q <= data_buf_v_d;
      data_buf_q   <= data_buf_d;
      drop_cnt_q   <= drop_cnt_d;
      inst_q       <= inst_d;
    end
  end

  drop_cnt_overflow: assert property (@(posedge clk) disable iff (reset)
    !(drop_inc && !drop_dec && (drop_cnt_q == DROP_MAX)));

  assign load_src = data_buf_v_q ? data_buf_q : data_sram_rdata;

  mem_load_align u_align (
    .addr  (inst_q.result[1:0]),
    .ld_op (inst_q.ld_op),
    .rdata (load_src),
    .value (load_val)
  );

  always_comb begin
    final_result        = inst_q.res_from_mem ? load_val : inst_q.result;
    ws_out.rdcntid      = inst_q.rdcntid;
    ws_out.ertn         = inst_q.ertn;
    ws_out.csr_we       = inst_q.csr_we;
    ws_out.csr_rd       = inst_q.csr_rd;
    ws_out.csr_wmask    = inst_q.csr_wmask;
    ws_out.csr_num      = inst_q.csr_num;
    ws_out.ex_cause     = inst_q.ex_cause;
    ws_out.gr_we        = inst_q.gr_we & (inst_q.ex_cause == '0);
    ws_out.dest         = inst_q.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = inst_q.pc;

    ms_to_ws_valid = ms_valid_q & ms_ready_go & !ws_reflush_ms;
    ms_to_ws_bus   = ms_valid_q ? ws_out : '0;
    ms_to_ds_dest  = (ms_valid_q & inst_q.gr_we) ? inst_q.dest : 5'd0;
    // While a load is still waiting the value is stale, but decode is stalled then.
    ms_to_ds_value = ms_valid_q ? final_result : 32'd0;
`ifdef MS_LOAD_BYPASS_EN
    ms_value_from_mem = ms_valid_q & inst_q.res_from_mem & !data_buf_v_q & !resp_take;
`else
    ms_value_from_mem = ms_valid_q & inst_q.res_from_mem & !data_buf_v_q;
`endif
    ms_int = ms_valid_q & ((inst_q.ex_cause != '0) | inst_q.ertn);
    ms_csr = ms_valid_q & (inst_q.csr_we | inst_q.csr_rd);
    ms_tid = ms_valid_q & inst_q.rdcntid;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// single-instruction traffic checked against a behavioural model.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [143:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [136:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [4:0]   ms_to_ds_dest;
  logic [31:0]  ms_to_ds_value;
  logic         ms_value_from_mem;
  logic         ws_reflush_ms;
  logic         ms_int;
  logic         ms_csr;
  logic         ms_tid;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_dest     (ms_to_ds_dest),
    .ms_to_ds_value    (ms_to_ds_value),
    .ms_value_from_mem (ms_value_from_mem),
    .ws_reflush_ms     (ws_reflush_ms),
    .ms_int            (ms_int),
    .ms_csr            (ms_csr),
    .ms_tid            (ms_tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mem_we, rdcntid, ertn, csr_we, csr_rd;
    logic [31:0] wmask;
    logic [13:0] num;
    logic [16:0] exc;
    logic [4:0]  ld_op;
    logic        res, gr_we;
    logic [4:0]  dest;
    logic [31:0] result, pc;
  } inst_t;

  function automatic inst_t blank();
    inst_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic logic [143:0] enc(input inst_t i);
    return {i.mem_we, i.rdcntid, i.ertn, i.csr_we, i.csr_rd, i.wmask, i.num, i.exc,
            i.ld_op, i.res, i.gr_we, i.dest, i.result, i.pc};
  endfunction

  // Load extraction from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [1:0] a, input logic [4:0] op,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = a[1] ? (d >> 16) : (d & 32'hFFFF);
    case (op)
      5'b00001: return (b >= 32'd128)   ? b - 32'd256   : b;
      5'b00010: return b;
      5'b00100: return (h >= 32'd32768) ? h - 32'd65536 : h;
      5'b01000: return h;
      5'b10000: return d;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [136:0] exp_out(input inst_t i, input logic [31:0] data);
    logic [31:0] fr;
    fr = i.res ? ref_load(i.result[1:0], i.ld_op, data) : i.result;
    return {i.rdcntid, i.ertn, i.csr_we, i.csr_rd, i.wmask, i.num, i.exc,
            (i.gr_we && i.exc == 17'd0), i.dest, fr, i.pc};
  endfunction

  task automatic step(input logic v, input logic [143:0] bus, input logic ok,
                      input logic [31:0] rd, input logic wsa, input logic fl);
    @(negedge clk);
    es_to_ms_valid    = v;
    es_to_ms_bus      = bus;
    data_sram_data_ok = ok;
    data_sram_rdata   = rd;
    ws_allowin        = wsa;
    ws_reflush_ms     = fl;
    #1;
  endtask

  task automatic test_reset();
    step(0, '0, 0, 32'd0, 1, 0);
    checks++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
    checks++;
    if ({ms_to_ws_valid, ms_value_from_mem, ms_int, ms_csr, ms_tid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
                         {ms_to_ws_valid, ms_value_from_mem, ms_int, ms_csr, ms_tid});
    end
    checks++;
    if (ms_to_ws_bus !== '0 || ms_to_ds_dest !== 5'd0 || ms_to_ds_value !== 32'd0) begin
      errors++; $display("FAIL reset_buses: got bus=%h dest=%h value=%h expected zero",
                         ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_release_allowin: got %b expected 1", ms_allowin); end
  endtask

  task automatic test_ldw();
    inst_t i;
    i = blank();
    i.ld_op = 5'b10000; i.res = 1; i.gr_we = 1; i.dest = 5'd5;
    i.result = 32'h0000_1000; i.pc = 32'h1c00_0000;
    step(1, enc(i), 0, $urandom, 1, 0);
    checks++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL ldw_accept: got allowin=%b expected 1", ms_allowin); end
    for (int c = 0; c < 2; c++) begin
      step(0, '0, 0, $urandom, 1, 0);
      checks++;
      if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0 || ms_value_from_mem !== 1'b1
          || ms_to_ds_dest !== 5'd5) begin
        errors++; $display("FAIL ldw_wait: got valid=%b allowin=%b from_mem=%b dest=%h expected 0 0 1 05",
                           ms_to_ws_valid, ms_allowin, ms_value_from_mem, ms_to_ds_dest);
      end
    end
    step(0, '0, 1, 32'hDEAD_BEEF, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ldw_data: got valid=%b final=%h expected 1 deadbeef",
                         ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    checks++;
    if (ms_to_ws_bus !== exp_out(i, 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL ldw_bus: got %h expected %h", ms_to_ws_bus, exp_out(i, 32'hDEAD_BEEF));
    end
    step(0, '0, 0, $urandom, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      errors++; $display("FAIL ldw_leave: got valid=%b allowin=%b expected 0 1", ms_to_ws_valid, ms_allowin);
    end
  endtask

  task automatic test_extract();
    inst_t i;
    logic [31:0] rd;
    i = blank();
    i.ld_op = 5'b00001; i.res = 1; i.gr_we = 1; i.dest = 5'd6; i.result = 32'h0000_2003;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 1, 32'h80FF_0000, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL ldb_addr3: got valid=%b final=%h expected 1 ffffff80",
                         ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    i.ld_op = 5'b01000; i.result = 32'h0000_2002;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 1, 32'h80FF_0000, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_80FF) begin
      errors++; $display("FAIL ldhu_addr2: got valid=%b final=%h expected 1 000080ff",
                         ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    for (int n = 0; n < 16; n++) begin
      i.ld_op  = 5'(1 << $urandom_range(0, 4));
      i.result = $urandom;
      rd       = $urandom;
      step(1, enc(i), 0, $urandom, 1, 0);
      step(0, '0, 1, rd, 1, 0);
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== ref_load(i.result[1:0], i.ld_op, rd)) begin
        errors++; $display("FAIL extract_op%b_addr%0d: got valid=%b final=%h expected 1 %h", i.ld_op,
                           i.result[1:0], ms_to_ws_valid, ms_to_ws_bus[63:32],
                           ref_load(i.result[1:0], i.ld_op, rd));
      end
    end
  endtask

  task automatic test_buffered();
    inst_t i;
    i = blank();
    i.ld_op = 5'b10000; i.res = 1; i.gr_we = 1; i.dest = 5'd7;
    i.result = 32'h0000_3000; i.pc = 32'h1c00_0040;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 1, 32'h1234_5678, 0, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin
      errors++; $display("FAIL buf_capture: got valid=%b allowin=%b expected 1 0", ms_to_ws_valid, ms_allowin);
    end
    for (int c = 0; c < 4; c++) begin
      step(0, '0, 0, $urandom, 0, 0);
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1234_5678
          || ms_value_from_mem !== 1'b0 || ms_to_ds_value !== 32'h1234_5678) begin
        errors++; $display("FAIL buf_hold: got valid=%b final=%h from_mem=%b fwd=%h expected 1 12345678 0 12345678",
                           ms_to_ws_valid, ms_to_ws_bus[63:32], ms_value_from_mem, ms_to_ds_value);
      end
    end
    step(0, '0, 0, $urandom, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ws_bus !== exp_out(i, 32'h1234_5678)) begin
      errors++; $display("FAIL buf_release: got valid=%b allowin=%b bus=%h expected 1 1 %h",
                         ms_to_ws_valid, ms_allowin, ms_to_ws_bus, exp_out(i, 32'h1234_5678));
    end
    step(0, '0, 0, $urandom, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL buf_leave: got valid=%b expected 0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_drop();
    inst_t i;
    i = blank();
    i.ld_op = 5'b10000; i.res = 1; i.gr_we = 1; i.dest = 5'd3; i.result = 32'h0000_4000;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 0, $urandom, 1, 1);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ms_to_ws_valid); end
    i.dest = 5'd9; i.result = 32'h0000_4004;
    step(1, enc(i), 0, $urandom, 1, 0);
    checks++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL flush_empty: got allowin=%b expected 1", ms_allowin); end
    step(0, '0, 1, 32'h0000_0001, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_value_from_mem !== 1'b1) begin
      errors++; $display("FAIL drop_stale: got valid=%b from_mem=%b expected 0 1", ms_to_ws_valid, ms_value_from_mem);
    end
    step(0, '0, 1, 32'h0000_0002, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_0002) begin
      errors++; $display("FAIL drop_second: got valid=%b final=%h expected 1 00000002",
                         ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    i.result = 32'h0000_4008;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 1, 32'h0000_0033, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_0033) begin
      errors++; $display("FAIL drop_cleared: got valid=%b final=%h expected 1 00000033",
                         ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
  endtask

  task automatic test_ale_store();
    inst_t i;
    i = blank();
    i.mem_we = 1; i.exc = 17'(1 << 3); i.gr_we = 1; i.dest = 5'd4;
    i.result = 32'h0000_1001; i.pc = 32'h1c00_0080;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 0, $urandom, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_int !== 1'b1 || ms_to_ws_bus[69] !== 1'b0) begin
      errors++; $display("FAIL ale_pass: got valid=%b allowin=%b int=%b gr_we=%b expected 1 1 1 0",
                         ms_to_ws_valid, ms_allowin, ms_int, ms_to_ws_bus[69]);
    end
    checks++;
    if (ms_to_ws_bus !== exp_out(i, 32'd0)) begin
      errors++; $display("FAIL ale_bus: got %h expected %h", ms_to_ws_bus, exp_out(i, 32'd0));
    end
    step(0, '0, 0, $urandom, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_int !== 1'b0) begin
      errors++; $display("FAIL ale_leave: got valid=%b int=%b expected 0 0", ms_to_ws_valid, ms_int);
    end
  endtask

  task automatic test_async_reset();
    inst_t i;
    i = blank();
    i.ld_op = 5'b10000; i.res = 1; i.gr_we = 1; i.dest = 5'd12; i.result = 32'h0000_5000;
    i.csr_rd = 1; i.rdcntid = 1;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 0, $urandom, 1, 0);
    checks++;
    if (ms_value_from_mem !== 1'b1 || ms_csr !== 1'b1 || ms_tid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got from_mem=%b csr=%b tid=%b expected 1 1 1",
                         ms_value_from_mem, ms_csr, ms_tid);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ms_allowin !== 1'b1 || {ms_to_ws_valid, ms_value_from_mem, ms_int, ms_csr, ms_tid} !== 5'b0
        || ms_to_ws_bus !== '0 || ms_to_ds_dest !== 5'd0 || ms_to_ds_value !== 32'd0) begin
      errors++; $display("FAIL areset_now: got allowin=%b flags=%b dest=%h value=%h expected 1 00000 00 0",
                         ms_allowin, {ms_to_ws_valid, ms_value_from_mem, ms_int, ms_csr, ms_tid},
                         ms_to_ds_dest, ms_to_ds_value);
    end
    @(negedge clk);
    reset = 1'b0;
    i.csr_rd = 0; i.rdcntid = 0;
    step(1, enc(i), 0, $urandom, 1, 0);
    step(0, '0, 1, 32'h0000_0055, 1, 0);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_0055) begin
      errors++; $display("FAIL areset_after: got valid=%b final=%h expected 1 00000055",
                         ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
  endtask

  task automatic test_random();
    inst_t       i;
    int          kind, lat, cyc;
    logic        need, got, done, exp_valid, exp_fm;
    logic [31:0] resp, cur;
    for (int n = 0; n < 40; n++) begin
      i = blank();
      kind      = $urandom_range(0, 2);
      i.rdcntid = 1'($urandom); i.ertn = 1'($urandom);
      i.csr_we  = 1'($urandom); i.csr_rd = 1'($urandom);
      i.wmask   = $urandom;     i.num    = 14'($urandom);
      i.gr_we   = 1'($urandom); i.dest   = 5'($urandom);
      i.result  = $urandom;     i.pc     = $urandom;
      if (kind == 1) begin
        i.res   = 1;
        i.ld_op = 5'(1 << $urandom_range(0, 4));
      end else begin
        i.mem_we = (kind == 2);
        if ($urandom_range(0, 3) == 0) i.exc = 17'(1 << $urandom_range(0, 16));
      end
      need = (i.res || i.mem_we) && (i.exc == 17'd0);
      lat  = $urandom_range(0, 3);
      got  = 0; done = 0; cyc = 0; resp = '0;
      step(1, enc(i), 0, $urandom, 1'($urandom), 0);
      checks++;
      if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rnd%0d_accept: got allowin=%b expected 1", n, ms_allowin); end
      while (!done && cyc < 60) begin
        step(0, '0, need && !got && (cyc == lat), $urandom, $urandom_range(0, 2) != 0, 0);
        exp_valid = !need || got || data_sram_data_ok;
        cur       = data_sram_data_ok ? data_sram_rdata : resp;
`ifdef MS_LOAD_BYPASS_EN
        exp_fm    = i.res && !got && !data_sram_data_ok;
`else
        exp_fm    = i.res && !got;
`endif
        checks++;
        if (ms_to_ws_valid !== exp_valid || ms_value_from_mem !== exp_fm) begin
          errors++; $display("FAIL rnd%0d_valid: got valid=%b from_mem=%b expected %b %b",
                             n, ms_to_ws_valid, ms_value_from_mem, exp_valid, exp_fm);
        end
        checks++;
        if (ms_int !== (i.exc != 17'd0 || i.ertn) || ms_csr !== (i.csr_we || i.csr_rd)
            || ms_tid !== i.rdcntid || ms_to_ds_dest !== (i.gr_we ? i.dest : 5'd0)) begin
          errors++; $display("FAIL rnd%0d_side: got int=%b csr=%b tid=%b dest=%h", n,
                             ms_int, ms_csr, ms_tid, ms_to_ds_dest);
        end
        if (!i.res || got) begin
          checks++;
          if (ms_to_ds_value !== (i.res ? ref_load(i.result[1:0], i.ld_op, resp) : i.result)) begin
            errors++; $display("FAIL rnd%0d_fwd: got %h expected %h", n, ms_to_ds_value,
                               i.res ? ref_load(i.result[1:0], i.ld_op, resp) : i.result);
          end
        end
        if (exp_valid && ws_allowin) begin
          checks++;
          if (ms_to_ws_bus !== exp_out(i, cur)) begin
            errors++; $display("FAIL rnd%0d_bus: got %h expected %h", n, ms_to_ws_bus, exp_out(i, cur));
          end
          $display("txn %0d kind=%0d pc=%h final=%h cycles=%0d", n, kind, i.pc, ms_to_ws_bus[63:32], cyc);
          done = 1;
        end
        if (data_sram_data_ok) begin
          got  = 1;
          resp = data_sram_rdata;
        end
        cyc++;
      end
      if (!done) begin
        errors++; $display("FAIL rnd%0d_timeout: got no writeback handshake expected one within 60 cycles", n);
      end
    end
  endtask

  initial begin
    reset             = 1'b1;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_reflush_ms     = 1'b0;
    test_reset();
    test_ldw();
    test_extract();
    test_buffered();
    test_flush_drop();
    test_ale_store();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1);
  end

endmodule
